// File: rtl/msrv32_pkg.sv
// Shared encodings for the store path: size codes, FSM states and byte-lane masks.
package msrv32_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } state_t;

  localparam logic [3:0] MASK_B0   = 4'b0001;
  localparam logic [3:0] MASK_H_LO = 4'b0011;
  localparam logic [3:0] MASK_H_HI = 4'b1100;
  localparam logic [3:0] MASK_W    = 4'b1111;

endpackage

// File: rtl/msrv32_store_align.sv
// Lane replication, byte-write mask and alignment check for one store request.
module msrv32_store_align
  import msrv32_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [31:0] wdata,
  output logic [3:0]  mask,
  output logic        misaligned
);

  // Size 2'b11 falls into the word branch and behaves exactly like SW.
  always_comb begin
    wdata      = rs2;
    mask       = MASK_W;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wdata = {4{rs2[7:0]}};
        mask  = MASK_B0 << addr_lo;
      end
      SZ_H: begin
        wdata      = {2{rs2[15:0]}};
        mask       = addr_lo[1] ? MASK_H_HI : MASK_H_LO;
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
  end

endmodule

// File: rtl/msrv32_store_unit.sv
// Store unit: accepts SB/SH/SW requests and runs an address-then-data write on the data bus.
module msrv32_store_unit
  import msrv32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              mem_wr_req_in,
  input  logic [1:0]        store_size_in,
  input  logic [ADDR_W-1:0] iadder_in,
  input  logic [DATA_W-1:0] rs2_in,
  input  logic              ms_riscv32_mp_data_hready_in,
  input  logic              ahb_resp_in,
  output logic              ms_riscv32_mp_dmwr_req_out,
  output logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out,
  output logic [3:0]        ms_riscv32_mp_dmwr_mask_out,
  output logic [DATA_W-1:0] ms_riscv32_mp_dmdata_out,
  output logic              su_busy_out,
  output logic              su_done_out,
  output logic              su_err_out,
  output logic              misaligned_store_out
);

  state_t            state, state_nxt;
  logic              accept, reject, done_nxt, err_nxt;
  logic [DATA_W-1:0] wdata_p0;
  logic [3:0]        mask_p0;
  logic              mis_p0;
  logic [ADDR_W-1:0] addr_p1;
  logic [3:0]        mask_p1;
  logic [DATA_W-1:0] data_p1;
  logic              done_p1, err_p1, mis_p1;

  msrv32_store_align u_align (
    .size       (store_size_in),
    .addr_lo    (iadder_in[1:0]),
    .rs2        (rs2_in),
    .wdata      (wdata_p0),
    .mask       (mask_p0),
    .misaligned (mis_p0)
  );

  // Next-state decode; requests are only looked at in IDLE, so the completing DATA cycle ignores them.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_wr_req_in) begin
          if (mis_p0) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (ms_riscv32_mp_data_hready_in) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (ms_riscv32_mp_data_hready_in) begin
          state_nxt = ST_IDLE;
          err_nxt   = ahb_resp_in;
          done_nxt  = ~ahb_resp_in;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, status pulses and the bus-facing address/mask/data registers captured at accept.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state   <= ST_IDLE;
      done_p1 <= 1'b0;
      err_p1  <= 1'b0;
      mis_p1  <= 1'b0;
      addr_p1 <= '0;
      mask_p1 <= '0;
      data_p1 <= '0;
    end else begin
      state   <= state_nxt;
      done_p1 <= done_nxt;
      err_p1  <= err_nxt;
      mis_p1  <= reject;
      if (accept) begin
        addr_p1 <= {iadder_in[ADDR_W-1:2], 2'b00};
        mask_p1 <= mask_p0;
        data_p1 <= wdata_p0;
      end
    end
  end

  assign ms_riscv32_mp_dmwr_req_out  = (state == ST_ADDR);
  assign su_busy_out                 = (state != ST_IDLE);
  assign ms_riscv32_mp_dmaddr_out    = addr_p1;
  assign ms_riscv32_mp_dmwr_mask_out = mask_p1;
  assign ms_riscv32_mp_dmdata_out    = data_p1;
  assign su_done_out                 = done_p1;
  assign su_err_out                  = err_p1;
  assign misaligned_store_out        = mis_p1;

endmodule

// File: tb/tb_msrv32_store_unit.sv
// Scoreboard bench for the store unit: driver pushes expected outcomes, negedge monitor compares.
module tb_msrv32_store_unit;

  logic        clk = 1'b0;
  logic        rst, req, hready, resp;
  logic [1:0]  size;
  logic [31:0] iaddr, rs2;
  logic        dmwr_req, busy, done, err, mis;
  logic [31:0] dm_addr, dm_data;
  logic [3:0]  dm_mask;

  always #5 clk = ~clk;

  msrv32_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .mem_wr_req_in                (req),
    .store_size_in                (size),
    .iadder_in                    (iaddr),
    .rs2_in                       (rs2),
    .ms_riscv32_mp_data_hready_in (hready),
    .ahb_resp_in                  (resp),
    .ms_riscv32_mp_dmwr_req_out   (dmwr_req),
    .ms_riscv32_mp_dmaddr_out     (dm_addr),
    .ms_riscv32_mp_dmwr_mask_out  (dm_mask),
    .ms_riscv32_mp_dmdata_out     (dm_data),
    .su_busy_out                  (busy),
    .su_done_out                  (done),
    .su_err_out                   (err),
    .misaligned_store_out         (mis)
  );

  typedef struct {
    bit          mis;
    bit          err;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    int          busy_cyc;
    int          addr_cyc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a store of nb bytes must sit on an nb-aligned offset, occupies lanes
  // [start, start+nb) and every lane carries byte (lane mod nb) of rs2.
  function automatic exp_t model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                 input int wa, input int wd, input bit rsp);
    exp_t e;
    int   nb, off, start;
    nb      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off     = int'(a % 4);
    start   = off - (off % nb);
    e.mis   = (off % nb) != 0;
    e.err   = rsp;
    e.addr  = a - 32'(off);
    e.mask  = '0;
    e.data  = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= start && i < start + nb) e.mask[i] = 1'b1;
      e.data[8*i +: 8] = d[8*(i % nb) +: 8];
    end
    e.busy_cyc = 2 + wa + wd;
    e.addr_cyc = 1 + wa;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and plays the bus side with wa/wd wait cycles in ADDR/DATA.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int wa, input int wd, input bit rsp, input bit scramble, input bit keep);
    exp_t e;
    e = model(sz, a, d, wa, wd, rsp);
    q.push_back(e);
    req = 1'b1; size = sz; iaddr = a; rs2 = d;
    hready = 1'($urandom_range(0, 1));
    resp = 1'($urandom_range(0, 1));
    step();
    if (e.mis) begin
      if (!keep) req = 1'b0;
      hready = 1'b0; resp = 1'b0;
      return;
    end
    if (scramble) begin
      size = 2'($urandom_range(0, 3)); iaddr = $urandom; rs2 = $urandom;
    end else if (!keep) begin
      req = 1'b0;
    end
    hready = 1'b0;
    repeat (wa) begin
      resp = 1'($urandom_range(0, 1));
      step();
    end
    hready = 1'b1;
    step();
    hready = 1'b0;
    repeat (wd) begin
      resp = 1'($urandom_range(0, 1));
      step();
    end
    hready = 1'b1; resp = rsp;
    step();
    hready = 1'b0; resp = 1'b0;
    if (!keep) req = 1'b0;
  endtask

  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_mask;
  bit          in_txn = 0, unstable = 0, prev_req = 0;
  int          bcnt = 0, acnt = 0, phases = 0;
  exp_t        me;

  // Monitor: tracks each busy period and checks it against the oldest expected outcome on its pulse.
  always @(negedge clk) begin
    if (rst) begin
      in_txn   = 0;
      prev_req = 0;
    end else begin
      if (busy) begin
        if (!in_txn) begin
          in_txn = 1; bcnt = 0; acnt = 0; phases = 0; unstable = 0;
          cap_addr = dm_addr; cap_mask = dm_mask; cap_data = dm_data;
        end else if (dm_addr !== cap_addr || dm_mask !== cap_mask || dm_data !== cap_data) begin
          unstable = 1;
        end
        bcnt++;
        if (dmwr_req) begin
          acnt++;
          if (!prev_req) phases++;
        end
      end else if (dmwr_req) begin
        chk("req_without_busy", 32'(dmwr_req), 32'd0);
      end
      prev_req = dmwr_req;
      if (done || err || mis) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {29'd0, mis, err, done}, 32'd0);
        end else begin
          me = q.pop_front();
          chk("pulse_kind", {29'd0, mis, err, done},
              {29'd0, me.mis, me.err && !me.mis, !me.err && !me.mis});
          if (me.mis) begin
            chk("mis_busy", 32'(busy), 32'd0);
            chk("mis_no_txn", 32'(in_txn), 32'd0);
          end else begin
            chk("addr", cap_addr, me.addr);
            chk("mask", 32'(cap_mask), 32'(me.mask));
            chk("data", cap_data, me.data);
            chk("held_stable", 32'(unstable), 32'd0);
            chk("busy_cycles", 32'(bcnt), 32'(me.busy_cyc));
            chk("addr_cycles", 32'(acnt), 32'(me.addr_cyc));
            chk("addr_phases", 32'(phases), 32'd1);
            chk("idle_on_pulse", 32'(busy), 32'd0);
          end
        end
        in_txn = 0;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"},  32'(dmwr_req), 32'd0);
    chk({tag, "_addr"}, dm_addr, 32'd0);
    chk({tag, "_mask"}, 32'(dm_mask), 32'd0);
    chk({tag, "_data"}, dm_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err), 32'd0);
    chk({tag, "_mis"},  32'(mis), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; size = 2'd0; iaddr = '0; rs2 = '0; hready = 1'b0; resp = 1'b0;
    repeat (2) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Directed scenarios
    do_store(2'd0, 32'h0000_1003, 32'hAABB_CCDD, 0, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd1, 32'h0000_2002, 32'h1234_5678, 3, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd2, 32'h0000_3001, 32'h1111_1111, 0, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd1, 32'h0000_3001, 32'h2222_2222, 0, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd0, 32'h0000_3001, 32'h3333_3333, 0, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd2, 32'h0000_4000, 32'hCAFE_F00D, 0, 0, 1'b1, 1'b0, 1'b0);

    // Reset in DATA with hready low aborts silently
    req = 1'b1; size = 2'd2; iaddr = 32'h0000_5000; rs2 = 32'h1111_2222; hready = 1'b1;
    step();
    req = 1'b0; hready = 1'b1;
    step();
    hready = 1'b0; rst = 1'b1;
    step();
    check_all_zero("mid_reset");
    rst = 1'b0;
    do_store(2'd2, 32'h0000_5004, 32'h0102_0304, 0, 0, 1'b0, 1'b0, 1'b0);

    // Request held across completion: back-to-back transfers
    do_store(2'd2, 32'h0000_6000, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 1'b1);
    do_store(2'd2, 32'h0000_6000, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 1'b0);
    do_store(2'd3, 32'h0000_7008, 32'h5A5A_A5A5, 1, 2, 1'b0, 1'b1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      do_store(2'($urandom_range(0, 3)), $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (5) step();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
